// File: rtl/serial_capture_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_capture_buffer
//
// Serial sampler and capture memory for the plotter data path. A capture is
// requested with a one-cycle start pulse. While capturing, clk is divided down
// to a sample tick. At each tick one bit of the synchronised serial input is
// shifted into a WORD_W-bit word, LSB first. DEPTH words are written into an
// internal buffer. The buffer can be read by address at any time through a
// registered read port.
//
// Handshake: start is a single-cycle request. It is accepted only when busy is
// low, i.e. in IDLE or DONE. busy rises on the accepting edge and stays high
// until the edge that writes the last word. On that same edge done rises, and
// it stays high until the next accepted start. A start seen while busy is
// dropped, not queued.
//
// Parameters:
//   DIV     clk cycles per sample tick (>= 4)
//   WORD_W  bits per captured word (1..32)
//   DEPTH   words per capture (2..4096)
//   ADDR_W  read address width, ceil(log2(DEPTH))
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   data_in      serial input, asynchronous to clk
//   start        one-cycle capture request
//   rd_addr      read word address
//   rd_data      registered read data (0 for rd_addr >= DEPTH)
//   busy         capture in progress (FSM state CAPTURE)
//   done         full capture completed (FSM state DONE)
//   wr_count     words written in the current capture
//   sample_tick  one-cycle pulse on each sample instant
//
// Build option:
//   SERIAL_CAPTURE_MAJORITY_EN  when defined, the sampled bit is the majority
//   of the synchronised input over the tick edge and the two edges before it.
// -----------------------------------------------------------------------------
module serial_capture_buffer #(
    parameter int DIV    = 25000000,
    parameter int WORD_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_in,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              sample_tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int AW1   = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [AW1-1:0]   WORD_LAST = AW1'(DEPTH - 1);
    localparam logic [AW1-1:0]   DEPTH_CNT = AW1'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              sync1;
    logic              din_s;
    logic              sample_bit;
    logic [CNT_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bitcnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word_full;
    logic              tick;
    logic              word_done;
    logic              last_word;
    logic              start_cap;

    logic [WORD_W-1:0] mem [0:DEPTH-1];

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            din_s <= 1'b0;
        end else begin
            sync1 <= data_in;
            din_s <= sync1;
        end
    end

`ifdef SERIAL_CAPTURE_MAJORITY_EN
    // din_s itself is the newest of the three history bits. These two flops
    // hold its values at the previous two edges.
    logic [1:0] din_hist;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            din_hist <= 2'b00;
        end else begin
            din_hist <= {din_hist[0], din_s};
        end
    end

    assign sample_bit = (din_s & din_hist[0]) | (din_s & din_hist[1]) |
                        (din_hist[0] & din_hist[1]);
`else
    assign sample_bit = din_s;
`endif

    assign tick        = (state_q == S_CAPTURE) && (div_cnt == CNT_LAST);
    assign word_done   = tick && (bitcnt == BIT_LAST);
    assign last_word   = word_done && (wr_count == WORD_LAST);
    assign start_cap   = start && (state_q != S_CAPTURE);
    assign sample_tick = tick;
    assign busy        = (state_q == S_CAPTURE);
    assign done        = (state_q == S_DONE);

    // The word as it will be after this tick. It includes the current bit, so
    // a completed word can be written to memory on the same edge.
    always_comb begin
        word_full         = shreg;
        word_full[bitcnt] = sample_bit;
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CAPTURE;
            S_CAPTURE: if (last_word) state_d = S_DONE;
            S_DONE:    if (start) state_d = S_CAPTURE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Divider, bit counter, shift register and word counter. The divider
    // wraps to 0 on every tick, so it is already 0 when the capture ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt  <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            wr_count <= '0;
        end else if (start_cap) begin
            div_cnt  <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            wr_count <= '0;
        end else if (state_q == S_CAPTURE) begin
            if (tick) begin
                div_cnt <= '0;
                shreg   <= word_full;
                if (bitcnt == BIT_LAST) begin
                    bitcnt   <= '0;
                    // The last word moves wr_count to DEPTH.
                    wr_count <= wr_count + 1'b1;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Capture memory. It is not reset, so only words written in the
    // current capture are meaningful.
    always_ff @(posedge clk) begin
        if (word_done) begin
            mem[wr_count[ADDR_W-1:0]] <= word_full;
        end
    end

    // Registered read port with no write bypass. Addresses beyond the
    // buffer read as 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < DEPTH_CNT) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_serial_capture_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_serial_capture_buffer
//
// Bench for serial_capture_buffer with DIV=4, WORD_W=8, DEPTH=4, ADDR_W=2.
// A second instance with DEPTH=3 covers out-of-range reads.
//
// Stimulus drives each data bit for DIV cycles. The bits are placed so that
// the value registered two edges before every sample tick is the intended bit.
// The reference holds the captured words as plain arrays. It derives all
// status timing from the capture arithmetic: tick k at edge E0 + k*DIV,
// word n written at tick (n+1)*WORD_W, and done at E0 + DEPTH*WORD_W*DIV.
// -----------------------------------------------------------------------------
module tb_serial_capture_buffer;

    localparam int DIV    = 4;
    localparam int WORD_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int AW1    = ADDR_W + 1;
    localparam int CAP    = DIV * WORD_W * DEPTH;   // 128 cycles
    localparam int DEPTH2 = 3;
    localparam int CAP2   = DIV * WORD_W * DEPTH2;  // 96 cycles

`ifdef SERIAL_CAPTURE_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic              clk;
    logic              resetn;
    logic              data_in;
    logic              start;
    logic              start2;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr2;
    logic [WORD_W-1:0] rd_data;
    logic [WORD_W-1:0] rd_data2;
    logic              busy, done, busy2, done2;
    logic [ADDR_W:0]   wr_count, wr_count2;
    logic              sample_tick, sample_tick2;

    int n_checks;
    int n_fail;

    logic [WORD_W-1:0] cur_words [DEPTH];
    logic [WORD_W-1:0] exp_mem   [DEPTH];
    logic [WORD_W-1:0] exp_q[$];

    serial_capture_buffer #(
        .DIV(DIV), .WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .resetn(resetn), .data_in(data_in), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .wr_count(wr_count), .sample_tick(sample_tick)
    );

    serial_capture_buffer #(
        .DIV(DIV), .WORD_W(WORD_W), .DEPTH(DEPTH2), .ADDR_W(ADDR_W)
    ) dut2 (
        .clk(clk), .resetn(resetn), .data_in(data_in), .start(start2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2), .done(done2),
        .wr_count(wr_count2), .sample_tick(sample_tick2)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference ----------------
    // data_in value presented at edge E0+c of a capture of cur_words.
    function automatic logic stim(input int c, input int glitch_c);
        int b;
        int w;
        if (c == glitch_c) return 1'b1;
        if (c < 0) return 1'b0;
        b = (c + 1) / DIV;
        w = b / WORD_W;
        if (w >= DEPTH) return 1'b0;
        return cur_words[w][b % WORD_W];
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic run_capture(input int stray_c, input int glitch_c, input string tag);
        int  done_c;
        int  exp_wr;
        logic exp_busy, exp_done, exp_tick;
        done_c = -1;
        for (int c = 0; c <= CAP + 3; c++) begin
            @(negedge clk);
            start   = (c == 0) || (c == stray_c);
            data_in = stim(c, glitch_c);
            @(posedge clk);
            #1;
            exp_busy = (c < CAP);
            exp_done = (c >= CAP);
            exp_wr   = (c >= CAP) ? DEPTH : c / (DIV * WORD_W);
            exp_tick = (((c + 1) % DIV) == 0) && ((c + 1) <= CAP);
            if (done === 1'b1 && done_c < 0) done_c = c;
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL %s busy c=%0d got %b exp %b", tag, c, busy, exp_busy);
            end
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL %s done c=%0d got %b exp %b", tag, c, done, exp_done);
            end
            n_checks++;
            if (wr_count !== AW1'(exp_wr)) begin
                n_fail++;
                $display("FAIL %s wr_count c=%0d got %0d exp %0d", tag, c, wr_count, exp_wr);
            end
            n_checks++;
            if (sample_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL %s sample_tick c=%0d got %b exp %b", tag, c, sample_tick, exp_tick);
            end
        end
        start   = 1'b0;
        data_in = 1'b0;
        n_checks++;
        if (done_c != CAP) begin
            n_fail++;
            $display("FAIL %s done_latency got %0d exp %0d", tag, done_c, CAP);
        end
    endtask

    task automatic read_all(input string tag);
        int base;
        int a;
        logic [WORD_W-1:0] exp;
        base = $urandom_range(0, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) begin
            a = (base + i) % DEPTH;
            @(negedge clk);
            rd_addr = ADDR_W'(a);
            exp_q.push_back(exp_mem[a]);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (rd_data !== exp) begin
                n_fail++;
                $display("FAIL %s rd_data addr=%0d got %h exp %h", tag, a, rd_data, exp);
            end
        end
    endtask

    task automatic randomize_words();
        for (int i = 0; i < DEPTH; i++) cur_words[i] = WORD_W'($urandom_range(1, 255));
    endtask

    task automatic commit_words();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = cur_words[i];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rd_data, busy, done, wr_count, sample_tick} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got rd=%h busy=%b done=%b wr=%0d tick=%b exp all 0",
                     rd_data, busy, done, wr_count, sample_tick);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_nominal();
        cur_words[0] = 8'hA5;
        cur_words[1] = 8'h3C;
        cur_words[2] = 8'hFF;
        cur_words[3] = 8'h01;
        run_capture(-1, -1, "nominal");
        commit_words();
        read_all("nominal");
    endtask

    task automatic test_start_while_busy();
        randomize_words();
        run_capture(50, -1, "start_busy");
        commit_words();
        read_all("start_busy");
    endtask

    task automatic test_reset_mid_capture();
        randomize_words();
        for (int c = 0; c <= 43; c++) begin
            @(negedge clk);
            start   = (c == 0);
            data_in = stim(c, -1);
            if (c == 38) rd_addr = ADDR_W'(1);
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (wr_count !== AW1'(1) || sample_tick !== 1'b1 || rd_data !== exp_mem[1]) begin
            n_fail++;
            $display("FAIL pre_reset got wr=%0d tick=%b rd=%h exp 1 1 %h",
                     wr_count, sample_tick, rd_data, exp_mem[1]);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({rd_data, busy, done, wr_count, sample_tick} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got rd=%h busy=%b done=%b wr=%0d tick=%b exp all 0",
                     rd_data, busy, done, wr_count, sample_tick);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn  = 1'b1;
        data_in = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_count !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle got busy=%b done=%b wr=%0d exp 0 0 0", busy, done, wr_count);
        end
        // Word 0 was completed before reset; the rest keep the older capture.
        exp_mem[0] = cur_words[0];
        read_all("mem_after_reset");
    endtask

    task automatic test_random_captures();
        for (int r = 0; r < 2; r++) begin
            randomize_words();
            run_capture(-1, -1, "random");
            commit_words();
            read_all("random");
        end
    endtask

    task automatic test_recapture_from_done();
        for (int i = 0; i < DEPTH; i++) cur_words[i] = 8'h00;
        run_capture(-1, -1, "recapture");
        commit_words();
        read_all("recapture");
    endtask

    task automatic test_majority_filter();
        for (int i = 0; i < DEPTH; i++) cur_words[i] = 8'h00;
        // A single-cycle pulse registered at E0+2 is the din_s value seen by
        // the first tick at E0+4. The two edges before that tick see 0.
        run_capture(-1, 2, "glitch");
        commit_words();
        exp_mem[0] = MAJ ? 8'h00 : 8'h01;
        read_all("glitch");
    endtask

    task automatic test_out_of_range();
        int done_c;
        done_c = -1;
        @(negedge clk);
        data_in  = 1'b1;
        rd_addr2 = ADDR_W'(3);
        repeat (3) @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_busy got %b exp 1", busy2);
        end
        for (int c = 1; c <= CAP2 + 10; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            @(posedge clk);
            #1;
            if (done2 === 1'b1 && done_c < 0) done_c = c;
        end
        n_checks++;
        if (done_c != CAP2) begin
            n_fail++;
            $display("FAIL oor_done_latency got %0d exp %0d", done_c, CAP2);
        end
        n_checks++;
        if (rd_data2 !== 8'h00) begin
            n_fail++;
            $display("FAIL oor_read3 got %h exp 00", rd_data2);
        end
        @(negedge clk);
        rd_addr2 = ADDR_W'(2);
        @(posedge clk);
        #1;
        n_checks++;
        if (rd_data2 !== 8'hFF) begin
            n_fail++;
            $display("FAIL oor_read2 got %h exp ff", rd_data2);
        end
        @(negedge clk);
        rd_addr2 = ADDR_W'(3);
        @(posedge clk);
        #1;
        n_checks++;
        if (rd_data2 !== 8'h00) begin
            n_fail++;
            $display("FAIL oor_read3_again got %h exp 00", rd_data2);
        end
        data_in = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        data_in  = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        rd_addr  = '0;
        rd_addr2 = '0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

        test_reset();
        test_nominal();
        test_start_while_busy();
        test_reset_mid_capture();
        test_random_captures();
        test_recapture_from_done();
        test_majority_filter();
        test_out_of_range();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
